// File: rtl/axis_fifo.sv
// AXI4-Stream FIFO with first-word fall-through output and full valid/ready backpressure.
// Define AXIS_FIFO_STATS_EN to add the beats_out / max_level statistics ports.
module axis_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [WIDTH-1:0]      s_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [WIDTH-1:0]      m_tdata,
  output logic [DEPTH_LOG2:0]   level
`ifdef AXIS_FIFO_STATS_EN
  ,
  output logic [31:0]           beats_out,
  output logic [DEPTH_LOG2:0]   max_level
`endif
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PtrOne = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem_q [Depth];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                aresetn_q;
  logic                empty, full, push, pop;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
               (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    // Registered reset flag keeps s_tready low for the first cycle after release.
    s_tready = !full && aresetn_q;
    m_tvalid = !empty;
    push     = s_tvalid && s_tready;
    pop      = m_tvalid && m_tready;
    m_tdata  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    level    = wr_ptr_q - rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      aresetn_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      aresetn_q <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define validity.
  always_ff @(posedge aclk) begin
    if (push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= s_tdata;
    end
  end

`ifdef AXIS_FIFO_STATS_EN
  logic [31:0]         beats_out_q;
  logic [DEPTH_LOG2:0] max_level_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      beats_out_q <= '0;
      max_level_q <= '0;
    end else begin
      if (pop) begin
        beats_out_q <= beats_out_q + 32'd1;
      end
      if (level > max_level_q) begin
        max_level_q <= level;
      end
    end
  end

  assign beats_out = beats_out_q;
  assign max_level = max_level_q;
`else
  // Statistics counters are compiled out.
`endif

endmodule

// File: tb/tb_axis_fifo.sv
// Directed vector table plus a scoreboarded random-backpressure run for axis_fifo.
module tb_axis_fifo;

  logic       aclk;
  logic       aresetn;
  logic       s_tvalid;
  logic       s_tready;
  logic [7:0] s_tdata;
  logic       m_tvalid;
  logic       m_tready;
  logic [7:0] m_tdata;
  logic [2:0] level;
`ifdef AXIS_FIFO_STATS_EN
  logic [31:0] beats_out;
  logic [2:0]  max_level;
`endif

  axis_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (2)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .level     (level)
`ifdef AXIS_FIFO_STATS_EN
    ,
    .beats_out (beats_out),
    .max_level (max_level)
`endif
  );

  initial aclk = 1'b1;
  always #5 aclk = ~aclk;

  typedef struct {
    logic        rstn;
    logic        sv;
    logic [7:0]  sd;
    logic        mr;
    logic        chk;
    logic        e_sr;
    logic        e_mv;
    logic [7:0]  e_md;
    logic [2:0]  e_lvl;
    logic        chk_st;
    logic [31:0] e_beats;
    logic [2:0]  e_max;
  } vec_t;

  vec_t vecs[$];
  int   nvec;
  int   nerr;

  function automatic void add(input logic rstn, input logic sv, input logic [7:0] sd,
                              input logic mr, input logic chk, input logic sr,
                              input logic mv, input logic [7:0] md, input logic [2:0] lvl);
    vec_t v;
    v.rstn = rstn; v.sv = sv; v.sd = sd; v.mr = mr; v.chk = chk;
    v.e_sr = sr; v.e_mv = mv; v.e_md = md; v.e_lvl = lvl;
    v.chk_st = 1'b0; v.e_beats = '0; v.e_max = '0;
    vecs.push_back(v);
  endfunction

  function automatic void set_stats(input logic [31:0] beats, input logic [2:0] mx);
    vecs[vecs.size()-1].chk_st  = 1'b1;
    vecs[vecs.size()-1].e_beats = beats;
    vecs[vecs.size()-1].e_max   = mx;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] stream [10];
  logic [7:0] q [$];
  int         sent, recv, cyc;
  logic       prev_stall, acc, popok;

  initial begin
    nvec = 0;
    nerr = 0;
    aresetn  = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    stream = '{8'd19, 8'd99, 8'd1, 8'd244, 8'd133, 8'd209, 8'd241, 8'd137, 8'd176, 8'd6};

    //  rstn sv  sd      mr  chk  sr  mv  md      lvl
    // Reset and release with a beat waiting.
    add(0, 0, 8'd0,   0, 0, 0, 0, 8'd0,   3'd0);
    add(0, 0, 8'd0,   0, 1, 0, 0, 8'd0,   3'd0);
    add(1, 1, 8'd19,  1, 1, 0, 0, 8'd0,   3'd0);
    add(1, 1, 8'd19,  1, 1, 1, 0, 8'd0,   3'd0);
    add(1, 0, 8'd0,   1, 1, 1, 1, 8'd19,  3'd1);
    add(1, 0, 8'd0,   1, 1, 1, 0, 8'd0,   3'd0);
    // Streaming at one beat per cycle.
    for (int k = 0; k < 10; k++) begin
      if (k == 0) add(1, 1, stream[k], 1, 1, 1, 0, 8'd0, 3'd0);
      else        add(1, 1, stream[k], 1, 1, 1, 1, stream[k-1], 3'd1);
    end
    add(1, 0, 8'd0,   1, 1, 1, 1, 8'd6,   3'd1);
    add(1, 0, 8'd0,   1, 1, 1, 0, 8'd0,   3'd0);
    // Fill with the consumer stalled; fifth beat must wait.
    add(1, 1, 8'd19,  0, 1, 1, 0, 8'd0,   3'd0);
    add(1, 1, 8'd99,  0, 1, 1, 1, 8'd19,  3'd1);
    add(1, 1, 8'd1,   0, 1, 1, 1, 8'd19,  3'd2);
    add(1, 1, 8'd244, 0, 1, 1, 1, 8'd19,  3'd3);
    add(1, 1, 8'd133, 0, 1, 0, 1, 8'd19,  3'd4);
    add(1, 1, 8'd133, 0, 1, 0, 1, 8'd19,  3'd4);
    // Full: pop-only cycle, then s_tready returns and 133 goes in.
    add(1, 1, 8'd133, 1, 1, 0, 1, 8'd19,  3'd4);
    add(1, 1, 8'd133, 1, 1, 1, 1, 8'd99,  3'd3);
    add(1, 0, 8'd0,   1, 1, 1, 1, 8'd1,   3'd3);
    add(1, 0, 8'd0,   1, 1, 1, 1, 8'd244, 3'd2);
    add(1, 0, 8'd0,   1, 1, 1, 1, 8'd133, 3'd1);
    add(1, 0, 8'd0,   1, 1, 1, 0, 8'd0,   3'd0);
    // Reset while three beats are held; old data must vanish.
    add(1, 1, 8'd19,  0, 1, 1, 0, 8'd0,   3'd0);
    add(1, 1, 8'd99,  0, 1, 1, 1, 8'd19,  3'd1);
    add(1, 1, 8'd1,   0, 1, 1, 1, 8'd19,  3'd2);
    add(0, 0, 8'd0,   1, 1, 1, 1, 8'd19,  3'd3);
    set_stats(32'd16, 3'd4);
    add(1, 1, 8'd6,   0, 1, 0, 0, 8'd0,   3'd0);
    set_stats(32'd0, 3'd0);
    add(1, 1, 8'd6,   0, 1, 1, 0, 8'd0,   3'd0);
    add(1, 0, 8'hAA,  1, 1, 1, 1, 8'd6,   3'd1);
    add(1, 0, 8'hAA,  1, 1, 1, 0, 8'd0,   3'd0);

    foreach (vecs[i]) begin
      aresetn  = vecs[i].rstn;
      s_tvalid = vecs[i].sv;
      s_tdata  = vecs[i].sd;
      m_tready = vecs[i].mr;
      @(negedge aclk);
      if (vecs[i].chk) begin
        nvec++;
        chk($sformatf("v%0d s_tready", i), 32'(s_tready), 32'(vecs[i].e_sr));
        chk($sformatf("v%0d m_tvalid", i), 32'(m_tvalid), 32'(vecs[i].e_mv));
        chk($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].e_lvl));
        if (vecs[i].e_mv)
          chk($sformatf("v%0d m_tdata", i), 32'(m_tdata), 32'(vecs[i].e_md));
`ifdef AXIS_FIFO_STATS_EN
        if (vecs[i].chk_st) begin
          chk($sformatf("v%0d beats_out", i), beats_out, vecs[i].e_beats);
          chk($sformatf("v%0d max_level", i), 32'(max_level), 32'(vecs[i].e_max));
        end
`endif
      end
      @(posedge aclk);
      #1;
    end

    // Random valid/ready against a queue scoreboard; FIFO is empty here.
    sent = 0;
    recv = 0;
    cyc  = 0;
    prev_stall = 1'b0;
    while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
      cyc++;
      s_tvalid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_tdata  = 8'($urandom_range(0, 255));
      m_tready = ($urandom_range(0, 3) != 0);
      @(negedge aclk);
      nvec++;
      chk($sformatf("rnd%0d m_tvalid", cyc), 32'(m_tvalid), 32'(q.size() > 0));
      chk($sformatf("rnd%0d s_tready", cyc), 32'(s_tready), 32'(q.size() < 4));
      chk($sformatf("rnd%0d level", cyc), 32'(level), 32'(q.size()));
      if (q.size() > 0) chk($sformatf("rnd%0d m_tdata", cyc), 32'(m_tdata), 32'(q[0]));
      if (prev_stall) chk($sformatf("rnd%0d valid_hold", cyc), 32'(m_tvalid), 32'd1);
      acc   = s_tvalid && (q.size() < 4);
      popok = m_tready && (q.size() > 0);
      prev_stall = (q.size() > 0) && !m_tready;
      @(posedge aclk);
      #1;
      if (popok) begin
        void'(q.pop_front());
        recv++;
      end
      if (acc) begin
        q.push_back(s_tdata);
        sent++;
      end
    end
    nvec++;
    chk("rnd beats_received", 32'(recv), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axis_fifo.md
Name: axis_fifo

Overview:
- Synchronous AXI4-Stream FIFO placed directly downstream of axis_master.
- Decouples the master's tdata stream from a consumer that may stall.
- Accepts beats on the slave side and replays them in order on the master side, with full valid/ready backpressure.
- Default sizing buffers a short burst (e.g. 19, 99, 1, 244, ...) without loss or reordering.

Parameters:
- WIDTH, 8, tdata width in bits.
- DEPTH_LOG2, 2, log2 of storage depth (default depth 4 entries); legal range 1..8.

Ports:
- aclk  input  1  clock; all logic on rising edge.
- aresetn  input  1  reset, synchronous, active-low.
- s_tvalid  input  1  upstream beat valid.
- s_tready  output  1  FIFO can accept a beat this cycle.
- s_tdata  input  WIDTH  upstream beat data.
- m_tvalid  output  1  FIFO holds a beat for downstream.
- m_tready  input  1  downstream accepts the beat.
- m_tdata  output  WIDTH  oldest stored beat.
- level  output  DEPTH_LOG2+1  number of stored beats, 0..2**DEPTH_LOG2.

Behaviour:
- Handshakes:
  - push = s_tvalid && s_tready.
  - pop = m_tvalid && m_tready.
  - Both are evaluated on the same rising edge.
- Storage and pointers:
  - Storage is 2**DEPTH_LOG2 entries of WIDTH bits, held in a register array.
  - The storage contents are not reset.
  - wr_ptr and rd_ptr are DEPTH_LOG2+1 bits wide; the extra MSB is the wrap bit.
  - Pointers wrap modulo 2**(DEPTH_LOG2+1) with no special case.
- Flags:
  - empty = (wr_ptr == rd_ptr).
  - full = low DEPTH_LOG2 bits equal and MSBs differ.
  - s_tready = !full && aresetn_q, where aresetn_q is a register set to 1 the cycle after reset releases.
  - m_tvalid = !empty.
  - m_tdata = mem[rd_ptr low bits], i.e. first-word fall-through.
- Reset (aresetn low at a rising edge):
  - wr_ptr=0, rd_ptr=0, level=0, m_tvalid=0, s_tready=0, aresetn_q=0.
  - Reset mid-operation discards all stored beats immediately; no pop completes that cycle.
- Latency:
  - A beat pushed into an empty FIFO appears on m_tvalid/m_tdata the next cycle.
  - There is no combinational s->m bypass.
  - No combinational path exists from m_tready to s_tready.
- Simultaneous push and pop:
  - Not full and not empty: both occur, level unchanged.
  - Empty: only the push can occur, since m_tvalid=0.
  - Full: only the pop can occur, since s_tready=0; s_tready rises the next cycle.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- AXI rules:
  - Once m_tvalid=1 it stays high and m_tdata stays stable until the pop.
  - s_tdata is sampled only on push; s_tdata while s_tvalid=0 is ignored.
- Order: strict FIFO, no drop, no duplication.

Optional Feature:
- Macro: AXIS_FIFO_STATS_EN.
- Defined:
  - Adds output port beats_out (32 bits), which counts pops and wraps at 2**32.
  - Adds output port max_level (DEPTH_LOG2+1 bits), a high-water mark of level.
  - Both reset to 0 with aresetn.
  - max_level updates the cycle after level exceeds it.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset release, s_tvalid=1 with s_tdata=19, m_tready=1:
  - s_tready=0 in the first cycle after release, 1 thereafter.
  - 19 appears on m_tdata one cycle after the push; level returns to 0.
- Stream 19, 99, 1, 244, 133, 209, 241, 137, 176, 6 with m_tready held 1:
  - Output sequence identical and in order.
  - level never exceeds 1; throughput of one beat per cycle.
- m_tready=0, push 19, 99, 1, 244:
  - level=4, s_tready=0 after the 4th push, m_tdata held at 19.
  - A 5th beat (133) is not accepted until one pop occurs.
- Full FIFO, then m_tready=1 with s_tvalid=1 (133):
  - Pop-only cycle first, s_tready rises the next cycle.
  - Output 19, 99, 1, 244, 133.
- Random m_tready and s_tvalid over 1000 beats:
  - Output matches a scoreboard.
  - m_tvalid never drops without a pop; m_tdata stable while stalled.
- aresetn low for one cycle while level=3:
  - Next cycle level=0, m_tvalid=0.
  - Old data never appears; a new beat 6 is output first.
  - With AXIS_FIFO_STATS_EN: beats_out=0 and max_level=0 after the reset.
